// File: rtl/disp_bright_ctl.sv
// ---------------------------------------------------------------------------
// disp_bright_ctl
//
// Brightness controller/arbiter producing the 8-bit level for the display
// PDM dimmer. Three requesters share the display brightness:
//   night-mode schedule (highest priority), ambient-light sensor, software.
// The selected target is reached either immediately (slew_en_i = 0) or by a
// timed fade of one step per STEP_US microsecond ticks (slew_en_i = 1).
//
// Parameters
//   STEP_US   tsc_1ppus_i pulses per slew step (1..65535)
//   INIT_PDM  reset value of the output and of the latched request levels
//
// Ports
//   clk          system clock, all logic on its rising edge
//   rst_n        asynchronous, active-low reset
//   tsc_1ppus_i  one-clk pulse per microsecond
//   sw_pdm_i     software brightness level, latched on sw_valid_i
//   sw_valid_i   one-clk strobe for sw_pdm_i
//   amb_pdm_i    ambient brightness level, latched on amb_valid_i
//   amb_valid_i  one-clk strobe for amb_pdm_i (also marks ambient as seen)
//   amb_en_i     ambient source permitted
//   night_req_i  night mode active
//   night_pdm_i  night brightness level, used live
//   slew_en_i    1 = fade toward target, 0 = jump to target
//   disp_pdm_o   brightness level to the dimmer
//   busy_o       high while the output has not yet reached the target
//   src_o        active source: 0 = SW, 1 = AMB, 2 = NIGHT
//
// Build option
//   DISP_BRIGHT_EXP_EN  when defined, fade steps scale with the current level
//                       (level >> 4, minimum 1) for a perceptually uniform
//                       fade; otherwise every step is 1.
// ---------------------------------------------------------------------------
module disp_bright_ctl #(
  parameter int unsigned STEP_US  = 1000,
  parameter logic [7:0]  INIT_PDM = 8'h80
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tsc_1ppus_i,
  input  logic [7:0] sw_pdm_i,
  input  logic       sw_valid_i,
  input  logic [7:0] amb_pdm_i,
  input  logic       amb_valid_i,
  input  logic       amb_en_i,
  input  logic       night_req_i,
  input  logic [7:0] night_pdm_i,
  input  logic       slew_en_i,
  output logic [7:0] disp_pdm_o,
  output logic       busy_o,
  output logic [1:0] src_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    UP   = 2'd1,
    DOWN = 2'd2
  } state_e;

  localparam logic [1:0]  SRC_SW    = 2'd0;
  localparam logic [1:0]  SRC_AMB   = 2'd1;
  localparam logic [1:0]  SRC_NIGHT = 2'd2;
  localparam logic [15:0] STEP_LAST = 16'(STEP_US - 1);

  logic [7:0]  sw_reg_q, sw_reg_d;
  logic [7:0]  amb_reg_q, amb_reg_d;
  logic        amb_seen_q, amb_seen_d;
  logic [7:0]  target_q, target_d;
  logic [1:0]  src_q, src_d;
  logic [15:0] presc_q, presc_d;
  logic        step_ce_q, step_ce_d;
  state_e      state_q;
  logic [7:0]  disp_q;
  logic        busy_q;

  logic [7:0]  up_step, dn_step;
  logic [7:0]  up_val, dn_val;

  // Request latches and fixed-priority arbitration. The arbitration reads the
  // already-latched request registers, so a strobe reaches the target two
  // edges after it is sampled.
  always_comb begin
    sw_reg_d   = sw_reg_q;
    amb_reg_d  = amb_reg_q;
    amb_seen_d = amb_seen_q;
    if (sw_valid_i) begin
      sw_reg_d = sw_pdm_i;
    end
    if (amb_valid_i) begin
      amb_reg_d  = amb_pdm_i;
      amb_seen_d = 1'b1;
    end

    target_d = sw_reg_q;
    src_d    = SRC_SW;
    if (night_req_i) begin
      target_d = night_pdm_i;
      src_d    = SRC_NIGHT;
    end else if (amb_en_i && amb_seen_q) begin
      target_d = amb_reg_q;
      src_d    = SRC_AMB;
    end
  end

  // Free-running microsecond prescaler; step_ce is a one-cycle pulse issued
  // the clock after the wrapping tick.
  always_comb begin
    presc_d   = presc_q;
    step_ce_d = 1'b0;
    if (tsc_1ppus_i) begin
      if (presc_q == STEP_LAST) begin
        presc_d   = 16'd0;
        step_ce_d = 1'b1;
      end else begin
        presc_d = presc_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sw_reg_q   <= INIT_PDM;
      amb_reg_q  <= INIT_PDM;
      amb_seen_q <= 1'b0;
      target_q   <= INIT_PDM;
      src_q      <= SRC_SW;
      presc_q    <= 16'd0;
      step_ce_q  <= 1'b0;
    end else begin
      sw_reg_q   <= sw_reg_d;
      amb_reg_q  <= amb_reg_d;
      amb_seen_q <= amb_seen_d;
      target_q   <= target_d;
      src_q      <= src_d;
      presc_q    <= presc_d;
      step_ce_q  <= step_ce_d;
    end
  end

  // Step size for the fade. The downward step uses (level - 1) so the step
  // sequence going down retraces the upward one.
`ifdef DISP_BRIGHT_EXP_EN
  logic [7:0] dn_base;
  always_comb begin
    dn_base = disp_q - 8'd1;
    up_step = (disp_q[7:4] == 4'd0) ? 8'd1 : {4'd0, disp_q[7:4]};
    dn_step = (dn_base[7:4] == 4'd0) ? 8'd1 : {4'd0, dn_base[7:4]};
  end
`else
  always_comb begin
    up_step = 8'd1;
    dn_step = 8'd1;
  end
`endif

  // Candidate next levels, clamped so a step never passes the target. Since
  // the target is itself 8-bit, clamping also keeps the level within 0..255.
  // The differences are only meaningful in the matching fade direction.
  always_comb begin
    up_val = (up_step >= (target_q - disp_q)) ? target_q : (disp_q + up_step);
    dn_val = (dn_step >= (disp_q - target_q)) ? target_q : (disp_q - dn_step);
  end

  // Fade state machine. A reversal of direction only changes state; the
  // first step in the new direction waits for the next step_ce, so the
  // output never jumps when the target moves mid-fade.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      disp_q  <= INIT_PDM;
      busy_q  <= 1'b0;
    end else if (!slew_en_i) begin
      disp_q  <= target_q;
      state_q <= IDLE;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (target_q > disp_q) begin
            state_q <= UP;
            busy_q  <= 1'b1;
          end else if (target_q < disp_q) begin
            state_q <= DOWN;
            busy_q  <= 1'b1;
          end else begin
            busy_q <= 1'b0;
          end
        end
        UP: begin
          if (target_q < disp_q) begin
            state_q <= DOWN;
            busy_q  <= 1'b1;
          end else if (target_q == disp_q) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else if (step_ce_q) begin
            disp_q <= up_val;
            if (up_val == target_q) begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end
          end
        end
        DOWN: begin
          if (target_q > disp_q) begin
            state_q <= UP;
            busy_q  <= 1'b1;
          end else if (target_q == disp_q) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else if (step_ce_q) begin
            disp_q <= dn_val;
            if (dn_val == target_q) begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign disp_pdm_o = disp_q;
  assign busy_o     = busy_q;
  assign src_o      = src_q;

endmodule
